// File: rtl/decode.sv
// Decode stage: instruction decode, register file with write-through, RAW interlock and halt.
// Optional feature macro: DECODE_INTERLOCK_EN (hazard detection and bubble insertion).
module decode #(
  parameter int unsigned WORD   = 32,
  parameter int unsigned ADDR   = 32,
  parameter int unsigned W_RD   = 4,
  parameter int unsigned W_OPC  = 4,
  parameter int unsigned W_DOPC = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR-1:0]   addr_i,
  output logic              stall_o,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   rd_num_i,
  input  logic [WORD-1:0]   rd_data_i,
  input  logic              stall_i,
  output logic              v_o,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   rd_num_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [ADDR-1:0]   origaddr_o
);

  localparam int unsigned NREG  = 1 << W_RD;
  localparam int unsigned W_IMM = 15;

  localparam logic [3:0] CLS_LAST_WB = 4'd7;
  localparam logic [3:0] CLS_NOP     = 4'd10;
  localparam logic [3:0] CLS_HALT    = 4'd11;
  localparam logic [W_DOPC-1:0] DOPC_TOP = {1'b1, {(W_DOPC-1){1'b0}}};

  typedef enum logic [0:0] {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WORD-1:0]   r_regs [NREG];
  logic              r_v;
  logic              r_wb;
  logic [W_RD-1:0]   r_rd_num;
  logic [WORD-1:0]   r_src;
  logic [WORD-1:0]   r_dest;
  logic [W_DOPC-1:0] r_dopc;
  logic [W_OPC-1:0]  r_opc;
  logic [ADDR-1:0]   r_addr;

  logic [3:0]        w_cls;
  logic [W_OPC-1:0]  w_opc;
  logic [W_RD-1:0]   w_rd;
  logic [W_RD-1:0]   w_rs;
  logic              w_imm;
  logic [W_IMM-1:0]  w_imm15;
  logic [WORD-1:0]   w_sext;
  logic [WORD-1:0]   w_dest_val;
  logic [WORD-1:0]   w_rs_val;
  logic [WORD-1:0]   w_src_val;
  logic [W_DOPC-1:0] w_dopc;
  logic              w_wb;
  logic              w_hazard;
  logic              w_stall;
  logic              w_accept;

  assign w_cls   = inst_i[31:28];
  assign w_opc   = inst_i[27:24];
  assign w_rd    = inst_i[23:20];
  assign w_rs    = inst_i[19:16];
  assign w_imm   = inst_i[15];
  assign w_imm15 = inst_i[14:0];
  assign w_sext  = {{(WORD-W_IMM){w_imm15[W_IMM-1]}}, w_imm15};

  // Register reads: r0 is hardwired to zero, a same-cycle write-back wins over the array.
  always_comb begin
    w_dest_val = '0;
    if (w_rd != '0) begin
      if (wb_i && (rd_num_i == w_rd)) w_dest_val = rd_data_i;
      else                            w_dest_val = r_regs[w_rd];
    end
  end

  always_comb begin
    w_rs_val = '0;
    if (w_rs != '0) begin
      if (wb_i && (rd_num_i == w_rs)) w_rs_val = rd_data_i;
      else                            w_rs_val = r_regs[w_rs];
    end
  end

  assign w_src_val = w_imm ? w_sext : w_rs_val;

  // Classes above halt fold into nop.
  always_comb begin
    w_dopc = DOPC_TOP >> CLS_NOP;
    if (w_cls <= CLS_HALT) w_dopc = DOPC_TOP >> w_cls;
  end

  assign w_wb = (w_cls <= CLS_LAST_WB);

`ifdef DECODE_INTERLOCK_EN
  assign w_hazard = v_i && r_v && r_wb && (r_rd_num != '0) &&
                    ((w_rd == r_rd_num) || (!w_imm && (w_rs == r_rd_num)));
`else
  assign w_hazard = 1'b0;
`endif

  assign w_stall  = stall_i || w_hazard || (r_state == S_HALT);
  assign w_accept = v_i && !w_stall;
  assign stall_o  = w_stall;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_accept && (w_cls == CLS_HALT)) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_i && (rd_num_i != '0)) begin
      r_regs[rd_num_i] <= rd_data_i;
    end
  end

  // Output register: holds under back-pressure, otherwise loads or issues a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v      <= 1'b0;
      r_wb     <= 1'b0;
      r_rd_num <= '0;
      r_src    <= '0;
      r_dest   <= '0;
      r_dopc   <= '0;
      r_opc    <= '0;
      r_addr   <= '0;
    end else if (!stall_i) begin
      r_v <= w_accept;
      if (w_accept) begin
        r_wb     <= w_wb;
        r_rd_num <= w_rd;
        r_src    <= w_src_val;
        r_dest   <= w_dest_val;
        r_dopc   <= w_dopc;
        r_opc    <= w_opc;
        r_addr   <= addr_i;
      end
    end
  end

  assign v_o        = r_v;
  assign wb_o       = r_wb;
  assign rd_num_o   = r_rd_num;
  assign src_o      = r_src;
  assign dest_o     = r_dest;
  assign dopc_o     = r_dopc;
  assign opc_o      = r_opc;
  assign origaddr_o = r_addr;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_decode;

  logic        clk;
  logic        rst;
  logic        v_i;
  logic [31:0] inst_i;
  logic [31:0] addr_i;
  logic        stall_o;
  logic        wb_i;
  logic [3:0]  rd_num_i;
  logic [31:0] rd_data_i;
  logic        stall_i;
  logic        v_o;
  logic [31:0] src_o;
  logic [31:0] dest_o;
  logic        wb_o;
  logic [3:0]  rd_num_o;
  logic [11:0] dopc_o;
  logic [3:0]  opc_o;
  logic [31:0] origaddr_o;

  decode dut (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .addr_i(addr_i),
    .stall_o(stall_o), .wb_i(wb_i), .rd_num_i(rd_num_i), .rd_data_i(rd_data_i),
    .stall_i(stall_i), .v_o(v_o), .src_o(src_o), .dest_o(dest_o), .wb_o(wb_o),
    .rd_num_o(rd_num_o), .dopc_o(dopc_o), .opc_o(opc_o), .origaddr_o(origaddr_o)
  );

  typedef struct packed {
    logic        wb;
    logic [3:0]  rd;
    logic [11:0] dopc;
    logic [3:0]  opc;
    logic [31:0] src;
    logic [31:0] dest;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   stalls;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input int cls, input int opc, input int rd,
                                     input int rs, input int imm, input int imm15);
    return {4'(cls), 4'(opc), 4'(rd), 4'(rs), 1'(imm), 15'(imm15)};
  endfunction

  function automatic exp_t mk_e(input int wb, input int rd, input int dopc, input int opc,
                                input logic [31:0] src, input logic [31:0] dest,
                                input logic [31:0] addr);
    exp_t e;
    e.wb = 1'(wb); e.rd = 4'(rd); e.dopc = 12'(dopc); e.opc = 4'(opc);
    e.src = src; e.dest = dest; e.addr = addr;
    return e;
  endfunction

  // Monitor: every instruction execute takes must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && v_o && !stall_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual dopc=0x%03h addr=0x%08h required=none",
                 dopc_o, origaddr_o);
      end else begin
        mon_e = q.pop_front();
        chk("sb_wb",   32'(wb_o),     32'(mon_e.wb));
        chk("sb_rd",   32'(rd_num_o), 32'(mon_e.rd));
        chk("sb_dopc", 32'(dopc_o),   32'(mon_e.dopc));
        chk("sb_opc",  32'(opc_o),    32'(mon_e.opc));
        chk("sb_src",  src_o,         mon_e.src);
        chk("sb_dest", dest_o,        mon_e.dest);
        chk("sb_addr", origaddr_o,    mon_e.addr);
      end
    end
  end

  // Present an instruction until accepted; returns the number of stalled cycles.
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr, input exp_t e,
                       output int n_stall);
    logic acc;
    acc = 1'b0;
    n_stall = 0;
    v_i = 1'b1; inst_i = inst; addr_i = addr;
    q.push_back(e);
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = !stall_o;
      if (!acc) n_stall++;
      @(posedge clk); #1;
    end
    chk("issue_accept", 32'(acc), 32'd1);
    v_i = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; v_i = 1'b0; inst_i = '0; addr_i = '0; wb_i = 1'b0;
    rd_num_i = '0; rd_data_i = '0; stall_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_v_o",    32'(v_o),     32'd0);
    chk("rst_stall",  32'(stall_o), 32'd0);
    chk("rst_dopc",   32'(dopc_o),  32'd0);
    chk("rst_dest",   dest_o,       32'd0);
    chk("rst_wb_o",   32'(wb_o),    32'd0);
    tick();

    // Write-back then read the same register.
    wb_i = 1'b1; rd_num_i = 4'd3; rd_data_i = 32'h1234;
    tick();
    wb_i = 1'b0;
    issue(mk(0, 1, 3, 0, 0, 0), 32'h100, mk_e(1, 3, 12'h800, 1, 32'h0, 32'h1234, 32'h100), stalls);

    // Immediate sign extension; rs field ignored for hazard when imm=1.
    issue(mk(5, 2, 4, 3, 1, 32'h7FFF), 32'h104,
          mk_e(1, 4, 12'h040, 2, 32'hFFFF_FFFF, 32'h0, 32'h104), stalls);
    chk("imm_no_hazard", 32'(stalls), 32'd0);

    // RAW on rs: producer then consumer back to back.
    issue(mk(0, 0, 2, 0, 1, 5), 32'h108, mk_e(1, 2, 12'h800, 0, 32'h5, 32'h0, 32'h108), stalls);
    v_i = 1'b1; inst_i = mk(5, 3, 5, 2, 0, 0); addr_i = 32'h10C;
`ifdef DECODE_INTERLOCK_EN
    q.push_back(mk_e(1, 5, 12'h040, 3, 32'h55, 32'h0, 32'h10C));
    @(negedge clk);
    chk("haz_stall", 32'(stall_o), 32'd1);
    tick();
    wb_i = 1'b1; rd_num_i = 4'd2; rd_data_i = 32'h55;
    @(negedge clk);
    chk("haz_bubble",  32'(v_o),     32'd0);
    chk("haz_release", 32'(stall_o), 32'd0);
    tick();
    wb_i = 1'b0; v_i = 1'b0;
`else
    q.push_back(mk_e(1, 5, 12'h040, 3, 32'h0, 32'h0, 32'h10C));
    @(negedge clk);
    chk("haz_stall", 32'(stall_o), 32'd0);
    tick();
    v_i = 1'b0;
    wb_i = 1'b1; rd_num_i = 4'd2; rd_data_i = 32'h55;
    tick();
    wb_i = 1'b0;
`endif

    // Producer writing r0 never interlocks.
    issue(mk(0, 0, 0, 0, 1, 1), 32'h110, mk_e(1, 0, 12'h800, 0, 32'h1, 32'h0, 32'h110), stalls);
    issue(mk(5, 0, 6, 0, 0, 0), 32'h114, mk_e(1, 6, 12'h040, 0, 32'h0, 32'h0, 32'h114), stalls);
    chk("r0_no_hazard", 32'(stalls), 32'd0);

    // RAW on rd.
    issue(mk(4, 1, 6, 3, 0, 0), 32'h118, mk_e(1, 6, 12'h080, 1, 32'h1234, 32'h0, 32'h118), stalls);
`ifdef DECODE_INTERLOCK_EN
    chk("rd_hazard_bubbles", 32'(stalls), 32'd1);
`else
    chk("rd_hazard_bubbles", 32'(stalls), 32'd0);
`endif

    // Execute back-pressure for three cycles with the next instruction waiting.
    stall_i = 1'b1;
    v_i = 1'b1; inst_i = mk(10, 0, 7, 1, 1, 32'h10); addr_i = 32'h11C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_stall", 32'(stall_o), 32'd1);
      chk("hold_v",     32'(v_o),     32'd1);
      chk("hold_src",   src_o,        32'h1234);
      chk("hold_dopc",  32'(dopc_o),  32'h080);
      chk("hold_addr",  origaddr_o,   32'h118);
      tick();
    end
    stall_i = 1'b0;
    issue(mk(10, 0, 7, 1, 1, 32'h10), 32'h11C,
          mk_e(0, 7, 12'h002, 0, 32'h10, 32'h0, 32'h11C), stalls);

    // Write-back to r0 is discarded, including the same-cycle bypass.
    wb_i = 1'b1; rd_num_i = 4'd0; rd_data_i = 32'hDEAD_BEEF;
    tick();
    issue(mk(14, 5, 0, 0, 0, 0), 32'h120, mk_e(0, 0, 12'h002, 5, 32'h0, 32'h0, 32'h120), stalls);
    wb_i = 1'b0;

    // Halt: issued once, then everything blocked until reset.
    issue(mk(11, 0, 0, 0, 0, 0), 32'h124, mk_e(0, 0, 12'h001, 0, 32'h0, 32'h0, 32'h124), stalls);
    v_i = 1'b1; inst_i = mk(0, 0, 1, 0, 1, 7); addr_i = 32'h128;
    @(negedge clk);
    chk("halt_stall_now", 32'(stall_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("halt_v_o",  32'(v_o),     32'd0);
      chk("halt_stall", 32'(stall_o), 32'd1);
    end
    tick();

    // Reset wins over a concurrent write-back and returns to RUN.
    rst = 1'b1; v_i = 1'b0;
    wb_i = 1'b1; rd_num_i = 4'd3; rd_data_i = 32'h9999;
    tick();
    rst = 1'b0; wb_i = 1'b0;
    @(negedge clk);
    chk("rerst_v_o",   32'(v_o),     32'd0);
    chk("rerst_stall", 32'(stall_o), 32'd0);
    tick();
    issue(mk(1, 2, 3, 0, 0, 0), 32'h200, mk_e(1, 3, 12'h400, 2, 32'h0, 32'h0, 32'h200), stalls);
    tick();
    tick();
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("end_v_o",  32'(v_o),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
